// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI master arbiter and its round-robin picker.
// Purely declarative: no logic, no latency, no flow control.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    localparam int DefaultMaster  = 0;
    localparam int MaxMasterCount = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i+1, wrapping modulo N.
// Zero latency; no flow control, found_o is low when req_i is empty.
module rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] cand;
    logic         hit;

    always_comb begin
        idx_o = '0;
        hit   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr_i) + k) % N);
            if (!hit && req_i[cand]) begin
                hit   = 1'b1;
                idx_o = cand;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Round-robin AXI master arbiter; grant registered one cycle after request, held from address to final response.
// Waiting masters simply keep VALID high; optional watchdog release under ARB_WATCHDOG_EN.
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int MasterCount    = 2,
    parameter int SelMasterCount = $clog2(MasterCount),
    parameter int WdtCycles      = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [MasterCount-1:0]    VALID_Master,
    input  logic                      AddrHandShake,
    input  logic                      RespHandShake,
    output logic [SelMasterCount-1:0] sel_Master,
    output logic                      grant_valid,
    output logic [MasterCount-1:0]    grant_onehot,
    output logic                      wdt_err
);

    if (MasterCount < 2 || MasterCount > MaxMasterCount ||
        SelMasterCount != $clog2(MasterCount) || WdtCycles < 2) begin : g_bad_params
        $error("axi_master_arbiter: illegal parameter set");
    end

    arb_state_e                state_q, state_d;
    logic [SelMasterCount-1:0] sel_q, sel_d;
    logic [SelMasterCount-1:0] ptr_q, ptr_d;
    logic [SelMasterCount-1:0] pick_idx;
    logic                      pick_found;
    logic                      wdt_fire;

    rr_pick #(
        .N (MasterCount),
        .W (SelMasterCount)
    ) u_pick (
        .req_i   (VALID_Master),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= SelMasterCount'(DefaultMaster);
            ptr_q   <= SelMasterCount'(MasterCount - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (AddrHandShake) state_d = BUSY;
            end
            BUSY: begin
                if (RespHandShake) begin
                    ptr_d   = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A forced release rotates priority exactly like a completed transaction.
        if (wdt_fire) begin
            ptr_d   = sel_q;
            state_d = IDLE;
        end
    end

    always_comb begin
        grant_valid = (state_q != IDLE);
        sel_Master  = sel_q;
        for (int i = 0; i < MasterCount; i++) begin
            grant_onehot[i] = grant_valid && (sel_q == SelMasterCount'(i));
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WdtW = $clog2(WdtCycles);

    logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic            wdt_err_q;

    // Completing handshake on the limit edge wins over the forced release.
    assign wdt_fire = (wdt_cnt_q == WdtW'(WdtCycles - 1)) &&
                      (((state_q == GRANT) && !AddrHandShake) ||
                       ((state_q == BUSY)  && !RespHandShake));

    always_comb begin
        wdt_cnt_d = (state_q == IDLE) ? '0 : wdt_cnt_q + 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_fire;
        end
    end

    assign wdt_err = wdt_err_q;
`else
    assign wdt_fire = 1'b0;
    assign wdt_err  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a 2-master and a 4-master instance checked every cycle
// against a transaction-level model, plus hand-computed grant expectations.
module tb_axi_master_arbiter;

`ifdef ARB_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [1:0] v2;
    logic       ah2, rh2;
    logic [0:0] sel2;
    logic       gv2, we2;
    logic [1:0] oh2;
    logic [3:0] v4;
    logic       ah4, rh4;
    logic [1:0] sel4;
    logic       gv4, we4;
    logic [3:0] oh4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    axi_master_arbiter #(.MasterCount(2), .SelMasterCount(1), .WdtCycles(16)) dut2 (
        .ACLK(clk), .ARESETn(rstn), .VALID_Master(v2), .AddrHandShake(ah2),
        .RespHandShake(rh2), .sel_Master(sel2), .grant_valid(gv2),
        .grant_onehot(oh2), .wdt_err(we2)
    );

    axi_master_arbiter #(.MasterCount(4), .SelMasterCount(2), .WdtCycles(1024)) dut4 (
        .ACLK(clk), .ARESETn(rstn), .VALID_Master(v4), .AddrHandShake(ah4),
        .RespHandShake(rh4), .sel_Master(sel4), .grant_valid(gv4),
        .grant_onehot(oh4), .wdt_err(we4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: owner is the master holding the bus (-1 = none).
    int m_owner[2] = '{-1, -1};
    int m_last[2]  = '{1, 3};
    bit m_addr[2]  = '{1'b0, 1'b0};
    int m_age[2]   = '{0, 0};
    int m_err[2]   = '{0, 0};

    task automatic model_step(int id, int n, int wdt, logic rst_n, logic [7:0] vld,
                              logic ah, logic rh);
        bit done;
        m_err[id] = 0;
        if (!rst_n) begin
            m_owner[id] = -1;
            m_addr[id]  = 1'b0;
            m_last[id]  = n - 1;
        end else if (m_owner[id] < 0) begin
            for (int k = 1; k <= n; k++) begin
                if (m_owner[id] < 0 && vld[(m_last[id] + k) % n]) begin
                    m_owner[id] = (m_last[id] + k) % n;
                    m_age[id]   = 0;
                    m_addr[id]  = 1'b0;
                end
            end
        end else begin
            done = 1'b0;
            m_age[id]++;
            if (!m_addr[id]) begin
                if (ah) begin
                    m_addr[id] = 1'b1;
                    done = 1'b1;
                end
            end else if (rh) begin
                m_last[id]  = m_owner[id];
                m_owner[id] = -1;
                done = 1'b1;
            end
            if (WDT_ON && !done && m_age[id] == wdt) begin
                m_err[id]   = 1;
                m_last[id]  = m_owner[id];
                m_owner[id] = -1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 2, 16, rstn, {6'b0, v2}, ah2, rh2);
        model_step(1, 4, 1024, rstn, {4'b0, v4}, ah4, rh4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m2_grant_valid", int'(gv2), int'(m_owner[0] >= 0));
            if (m_owner[0] >= 0) check("m2_sel", int'(sel2), m_owner[0]);
            check("m2_onehot", int'(oh2), (m_owner[0] >= 0) ? (1 << m_owner[0]) : 0);
            check("m2_wdt_err", int'(we2), m_err[0]);
            check("m4_grant_valid", int'(gv4), int'(m_owner[1] >= 0));
            if (m_owner[1] >= 0) check("m4_sel", int'(sel4), m_owner[1]);
            check("m4_onehot", int'(oh4), (m_owner[1] >= 0) ? (1 << m_owner[1]) : 0);
            check("m4_wdt_err", int'(we4), m_err[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int exp4[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int wait_cnt;
    bit seen;

    initial begin
        rstn = 1'b0;
        v2 = 2'b00; ah2 = 1'b0; rh2 = 1'b0;
        v4 = 4'b0000; ah4 = 1'b0; rh4 = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_grant_valid", int'(gv2), 0);
        check("reset_sel", int'(sel2), 0);
        check("reset_onehot", int'(oh2), 0);
        check("reset_wdt_err", int'(we2), 0);
        rstn = 1'b1;
        tick();

        // Both masters request: master 0 first, then master 1.
        v2 = 2'b11;
        tick();
        check("t1_first_valid", int'(gv2), 1);
        check("t1_first_sel", int'(sel2), 0);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; rh2 = 1'b1; tick();
        check("t1_release", int'(gv2), 0);
        rh2 = 1'b0; tick();
        check("t1_second_valid", int'(gv2), 1);
        check("t1_second_sel", int'(sel2), 1);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; rh2 = 1'b1; v2 = 2'b00; tick();
        rh2 = 1'b0; tick();

        // Only master 1, long BUSY phase.
        v2 = 2'b10;
        tick();
        check("t2_sel", int'(sel2), 1);
        check("t2_onehot", int'(oh2), 2);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; v2 = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold", int'(gv2), 1);
        end
        rh2 = 1'b1; tick();
        check("t2_release", int'(gv2), 0);
        rh2 = 1'b0; tick();

        // Address and response together while in GRANT: response ignored.
        v2 = 2'b01;
        tick();
        check("t3_sel", int'(sel2), 0);
        ah2 = 1'b1; rh2 = 1'b1; v2 = 2'b00; tick();
        check("t3_not_released", int'(gv2), 1);
        ah2 = 1'b0; rh2 = 1'b0; tick();
        check("t3_still_busy", int'(gv2), 1);
        rh2 = 1'b1; tick();
        check("t3_release", int'(gv2), 0);
        rh2 = 1'b0; tick();

        // Reset during BUSY restores master-0 priority.
        v2 = 2'b11;
        tick();
        check("t5_pre_sel", int'(sel2), 1);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; rstn = 1'b0; tick();
        check("t5_reset_valid", int'(gv2), 0);
        rstn = 1'b1; tick();
        check("t5_regrant_valid", int'(gv2), 1);
        check("t5_regrant_sel", int'(sel2), 0);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; rh2 = 1'b1; v2 = 2'b00; tick();
        rh2 = 1'b0; tick();

        // Four masters all requesting: strict rotation.
        v4 = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_rotation", int'(sel4), exp4[i]);
            check("t4_onehot", int'(oh4), 1 << exp4[i]);
            ah4 = 1'b1; tick();
            ah4 = 1'b0; rh4 = 1'b1;
            if (i == 7) v4 = 4'b0000;
            tick();
            rh4 = 1'b0;
        end
        tick();

`ifdef ARB_WATCHDOG_EN
        // No response: watchdog releases 16 cycles after GRANT entry.
        v2 = 2'b11;
        tick();
        check("t6_sel", int'(sel2), 1);
        ah2 = 1'b1; tick();
        ah2 = 1'b0;
        wait_cnt = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            wait_cnt++;
            if (we2) seen = 1'b1;
        end
        check("t6_wdt_seen", int'(seen), 1);
        check("t6_wdt_delay", wait_cnt, 16);
        check("t6_released", int'(gv2), 0);
        tick();
        check("t6_pulse_width", int'(we2), 0);
        check("t6_regrant_sel", int'(sel2), 0);
        ah2 = 1'b1; tick();
        ah2 = 1'b0; rh2 = 1'b1; v2 = 2'b00; tick();
        rh2 = 1'b0; tick();
`endif

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
Round-robin master arbiter placed directly upstream of the slave-select stage in the AXI interconnect. It picks one requesting master per transaction and forwards that master's index to the address mux. The grant is held from the address handshake until the response handshake completes, so the downstream slave select sees a single stable master for the whole transaction. One instance serves the read channel and one serves the write channel.

Parameters:
MasterCount, 2, number of masters arbitrated; legal range 2..8.
SelMasterCount, 1, width of the master index; equals clog2(MasterCount).
WdtCycles, 1024, watchdog limit in cycles; used only when ARB_WATCHDOG_EN is defined.

Ports:
ACLK  input  1  clock; all logic on rising edge.
ARESETn  input  1  synchronous, active-low reset.
VALID_Master  input  MasterCount  per-master ARVALID/AWVALID request.
AddrHandShake  input  1  VALID&READY on the granted master's address channel.
RespHandShake  input  1  final response handshake (RVALID&RREADY&RLAST, or BVALID&BREADY).
sel_Master  output  SelMasterCount  index of the granted master.
grant_valid  output  1  sel_Master is a live grant.
grant_onehot  output  MasterCount  one-hot decode of sel_Master, gated by grant_valid.
wdt_err  output  1  one-cycle pulse on a watchdog-forced release.

Behaviour:
- Reset (ARESETn=0 sampled at a rising edge):
  - state=IDLE, sel_Master=0, grant_valid=0, grant_onehot=0, wdt_err=0.
  - last_ptr=MasterCount-1, so master 0 has first priority.
  - Reset asserted in any state aborts that state at that edge; no release pulse is generated.
- State IDLE:
  - If VALID_Master!=0, choose the winner by round-robin search starting at last_ptr+1, wrapping modulo MasterCount.
  - Register the winner into sel_Master and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - grant_valid=1; sel_Master is frozen.
  - AddrHandShake=1: go to BUSY.
  - RespHandShake is ignored in this state.
  - If the granted master drops its VALID without a handshake, the grant is still held (AXI forbids dropping VALID); no re-arbitration.
- State BUSY:
  - grant_valid=1; sel_Master is frozen; AddrHandShake is ignored.
  - RespHandShake=1: set last_ptr=sel_Master and go to IDLE.
  - grant_valid falls on the next cycle.
- Latency:
  - Request first seen in IDLE at edge N gives grant_valid=1 after edge N, i.e. one registered cycle.
  - Response handshake at edge M gives IDLE after edge M; the next grant appears after edge M+1.
  - Minimum back-to-back spacing is one idle cycle.
- A request arriving while in GRANT or BUSY waits; it is never lost, because VALID is held per AXI.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,MasterCount-1,0. No master waits more than MasterCount-1 transactions.
- The arbitration search is purely combinational on VALID_Master and last_ptr; there is no arithmetic overflow because the index wraps modulo MasterCount.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - A counter of width clog2(WdtCycles) is cleared on entry to GRANT and increments each cycle in GRANT or BUSY.
  - When it reaches WdtCycles-1 with no completing handshake, the next edge forces IDLE and sets last_ptr=sel_Master.
  - wdt_err is high for exactly that one following cycle.
  - A completing handshake on the same edge as the limit takes precedence: normal transition, no wdt_err.
- Undefined: no counter is built and wdt_err is tied to 0.

Decomposition:
- Package axi_arb_pkg holds:
  - the state enum {IDLE, GRANT, BUSY} as a 2-bit logic type;
  - the DefaultMaster constant (0);
  - the MaxMasterCount constant (8).
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the winner index and a found flag. It is reused by the slave-side response arbiter.

Test Plan:
1. Reset, then VALID_Master=2'b11 held: sel_Master=0 and grant_valid=1 one cycle after; AddrHandShake then RespHandShake; next grant is sel_Master=1.
2. Only master 1 requests, at cycle 5: grant_valid=1 at cycle 6 with sel_Master=1 and grant_onehot=2'b10; grant holds through 10 BUSY cycles until RespHandShake.
3. In GRANT, assert AddrHandShake and RespHandShake together: state goes to BUSY, and grant is not released.
4. MasterCount=4, all requesting, 8 transactions: grant sequence is 0,1,2,3,0,1,2,3.
5. ARESETn=0 for one edge while in BUSY with sel_Master=1: next cycle grant_valid=0, and the next grant goes to master 0.
6. ARB_WATCHDOG_EN defined, WdtCycles=16: in BUSY with no response, wdt_err pulses for one cycle 16 cycles after entering GRANT, and the arbiter re-grants to the next requester.
